// File: rtl/npc_io_pkg.sv
// Shared board-I/O definitions: debounce FSM encoding, default stability window,
// and the counter-width helper used by the debounce blocks.
package npc_io_pkg;

   typedef enum logic {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } debState_e;

   localparam int unsigned STABLE_CYCLES_DEFAULT = 50000;

   // A window of one or two cycles still needs a one-bit counter.
   function automatic int unsigned cntWidth(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, stability counter, and registered
// rise/fall pulses on acceptance of a new level.
module debounce_bit
   import npc_io_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   input  logic run_i,
   input  logic load_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CW = cntWidth(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any matching sample restarts the window; the Nth differing one flips the level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (load_i) begin
         stable_d = sync2_q;
      end else if (run_i && (sync2_q != stable_q)) begin
         if (cnt_q == LAST) begin
            stable_d = ~stable_q;
            rise_d   = ~stable_q;
            fall_d   = stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;

endmodule

// File: rtl/key_debounce8.sv
// Eight-input switch debouncer feeding the priority encoder; a settle phase after
// reset loads the initial levels without emitting edge pulses.
module key_debounce8
   import npc_io_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             changed_o
);

   localparam int unsigned CW = cntWidth(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   debState_e     state_q;
   logic [CW-1:0] settleCnt_q;
   logic          valid_q;
   logic          loadNow;
   logic          runNow;

   assign loadNow = (state_q == SETTLE) && (settleCnt_q == LAST);
   assign runNow  = (state_q == RUN);

   // Settle counter parks at its last value once RUN is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SETTLE;
         settleCnt_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         case (state_q)
            SETTLE: begin
               if (settleCnt_q == LAST) begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
               end else begin
                  settleCnt_q <= settleCnt_q + 1'b1;
               end
            end
            RUN:     state_q <= RUN;
            default: state_q <= SETTLE;
         endcase
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (raw_i[i]),
         .run_i   (runNow),
         .load_i  (loadNow),
         .stable_o(stable_o[i]),
         .rise_o  (rise_o[i]),
         .fall_o  (fall_o[i])
      );
   end

   assign valid_o   = valid_q;
   assign changed_o = |{rise_o, fall_o};

endmodule

// File: tb/tb_key_debounce8.sv
// Bench for key_debounce8 with N=4: fixed vector table, hand-built corner sequences,
// and random input traffic compared against a sample-window reference model.
module tb_key_debounce8;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] raw_i = 8'h00;
   logic [7:0] stable_o, rise_o, fall_o;
   logic       valid_o, changed_o;

   int checks = 0;
   int failures = 0;

   key_debounce8 #(.WIDTH(8), .STABLE_CYCLES(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw_i),
      .stable_o (stable_o),
      .valid_o  (valid_o),
      .rise_o   (rise_o),
      .fall_o   (fall_o),
      .changed_o(changed_o)
   );

   always #5 clk = ~clk;

   // Reference: the level seen at edge e is raw_i sampled two edges earlier; after
   // the settle edge a bit flips when its last N seen samples all differ from it.
   logic [7:0] rawQ[$];
   logic [7:0] seenQ[$];
   logic [7:0] mStable = 8'h00, mRise = 8'h00, mFall = 8'h00, mCur = 8'h00;
   logic       mValid = 1'b0;
   logic       mFlip;
   int         mEdge = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rawQ.delete();
         seenQ.delete();
         mStable = 8'h00;
         mRise   = 8'h00;
         mFall   = 8'h00;
         mValid  = 1'b0;
         mEdge   = 0;
      end else begin
         mEdge++;
         mRise = 8'h00;
         mFall = 8'h00;
         mCur  = (rawQ.size() >= 2) ? rawQ[rawQ.size()-2] : 8'h00;
         rawQ.push_back(raw_i);
         seenQ.push_back(mCur);
         if (rawQ.size() > 8) void'(rawQ.pop_front());
         if (seenQ.size() > 8) void'(seenQ.pop_front());
         if (mEdge == N) begin
            mStable = mCur;
            mValid  = 1'b1;
         end else if (mEdge > N) begin
            for (int i = 0; i < 8; i++) begin
               mFlip = 1'b1;
               for (int k = 0; k < N; k++)
                  if (seenQ[seenQ.size()-1-k][i] == mStable[i]) mFlip = 1'b0;
               if (mFlip) begin
                  mStable[i] = ~mStable[i];
                  mRise[i]   = mStable[i];
                  mFall[i]   = ~mStable[i];
               end
            end
         end
      end
   end

   task automatic checkVal(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkVal("model_stable", stable_o, mStable);
      checkVal("model_valid", {7'd0, valid_o}, {7'd0, mValid});
      checkVal("model_rise", rise_o, mRise);
      checkVal("model_fall", fall_o, mFall);
      checkVal("model_changed", {7'd0, changed_o}, {7'd0, |{mRise, mFall}});
   endtask

   // Called at a falling edge: drive, let one rising edge pass, sample at the next fall.
   task automatic applyStimulus(input logic [7:0] v);
      raw_i = v;
      @(negedge clk);
      checkOutput();
   endtask

   typedef struct {
      logic [7:0] raw;
      logic [7:0] stable;
      logic [7:0] rise;
      logic [7:0] fall;
      logic       changed;
   } vec_t;

   vec_t vecs[21];
   logic [7:0] r;
   int riseCnt, fallCnt;

   initial begin
      vecs[0]  = '{8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[3]  = '{8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[5]  = '{8'h04, 8'h04, 8'h04, 8'h00, 1'b1};
      vecs[6]  = '{8'h04, 8'h04, 8'h00, 8'h00, 1'b0};
      vecs[7]  = '{8'h0F, 8'h04, 8'h00, 8'h00, 1'b0};
      vecs[8]  = '{8'h0F, 8'h04, 8'h00, 8'h00, 1'b0};
      vecs[9]  = '{8'h0F, 8'h04, 8'h00, 8'h00, 1'b0};
      vecs[10] = '{8'h0F, 8'h04, 8'h00, 8'h00, 1'b0};
      vecs[11] = '{8'h0F, 8'h04, 8'h00, 8'h00, 1'b0};
      vecs[12] = '{8'h0F, 8'h0F, 8'h0B, 8'h00, 1'b1};
      vecs[13] = '{8'h0F, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[14] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[15] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[16] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[17] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[18] = '{8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0};
      vecs[19] = '{8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1};
      vecs[20] = '{8'hF0, 8'hF0, 8'h00, 8'h00, 1'b0};

      // Reset with 8'hA5 held, then the settle sequence.
      raw_i = 8'hA5;
      repeat (3) @(negedge clk);
      checkVal("reset_stable", stable_o, 8'h00);
      checkVal("reset_valid", {7'd0, valid_o}, 8'h00);
      checkVal("reset_pulses", rise_o | fall_o | {7'd0, changed_o}, 8'h00);
      rst_n = 1'b1;
      for (int e = 1; e <= N; e++) begin
         applyStimulus(8'hA5);
         checkVal("settle_valid", {7'd0, valid_o}, (e == N) ? 8'h01 : 8'h00);
         checkVal("settle_stable", stable_o, (e == N) ? 8'hA5 : 8'h00);
         checkVal("settle_pulses", rise_o | fall_o | {7'd0, changed_o}, 8'h00);
      end

      repeat (8) applyStimulus(8'h00);
      checkVal("clear_stable", stable_o, 8'h00);

      // Clean edge, multi-bit change, and simultaneous rise/fall from the table.
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].raw);
         checkVal($sformatf("vec%0d_stable", i), stable_o, vecs[i].stable);
         checkVal($sformatf("vec%0d_rise", i), rise_o, vecs[i].rise);
         checkVal($sformatf("vec%0d_fall", i), fall_o, vecs[i].fall);
         checkVal($sformatf("vec%0d_changed", i), {7'd0, changed_o}, {7'd0, vecs[i].changed});
      end

      repeat (8) applyStimulus(8'h00);

      // A 3-cycle pulse on bit 7 is shorter than the window and must vanish.
      repeat (3) applyStimulus(8'h80);
      repeat (8) begin
         applyStimulus(8'h00);
         checkVal("glitch3_stable", stable_o, 8'h00);
         checkVal("glitch3_changed", {7'd0, changed_o}, 8'h00);
      end

      // A 4-cycle pulse is accepted, then released again.
      riseCnt = 0;
      fallCnt = 0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus((k < 4) ? 8'h80 : 8'h00);
         riseCnt += int'(rise_o[7]);
         fallCnt += int'(fall_o[7]);
      end
      checkVal("glitch4_rise_count", 8'(riseCnt), 8'd1);
      checkVal("glitch4_fall_count", 8'(fallCnt), 8'd1);
      checkVal("glitch4_final", stable_o, 8'h00);

      // Bounce on bit 1: the low sample restarts the window.
      r = 8'b0111_1011;
      for (int k = 0; k < 7; k++) begin
         applyStimulus(r[k] ? 8'h02 : 8'h00);
         checkVal("bounce_hold", stable_o, 8'h00);
      end
      applyStimulus(8'h02);
      checkVal("bounce_late", stable_o, 8'h00);
      applyStimulus(8'h02);
      checkVal("bounce_flip", stable_o, 8'h02);
      checkVal("bounce_rise", rise_o, 8'h02);
      checkVal("bounce_changed", {7'd0, changed_o}, 8'h01);

      // Reset while bit 3 is partway through its window.
      repeat (4) applyStimulus(8'h0A);
      rst_n = 1'b0;
      #1;
      checkVal("midrst_stable", stable_o, 8'h00);
      checkVal("midrst_valid", {7'd0, valid_o}, 8'h00);
      checkVal("midrst_pulses", rise_o | fall_o | {7'd0, changed_o}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= N; e++) begin
         applyStimulus(8'h0A);
         checkVal("resettle_valid", {7'd0, valid_o}, (e == N) ? 8'h01 : 8'h00);
         checkVal("resettle_stable", stable_o, (e == N) ? 8'h0A : 8'h00);
         checkVal("resettle_pulses", rise_o | fall_o | {7'd0, changed_o}, 8'h00);
      end

      // Random traffic with occasional changes, mixing short glitches and accepted edges.
      r = 8'h0A;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 5) == 0) r = 8'($urandom);
         applyStimulus(r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
